// File: rtl/mips_pkg.sv
// Shared widths and FSM state type for the writeback / register-file slice.
package mips_pkg;

    localparam int DATA_W     = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/wb_select.sv
// Writeback source select: load data or ALU result, chosen by MemtoReg.
module wb_select
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] i_mem_data,
    input  logic [DATA_W-1:0] i_alu_data,
    input  logic              i_memto_reg,
    output logic [DATA_W-1:0] o_wdata
);

    // Pure mux; the result also feeds the forwarding network upstream.
    always_comb begin
        o_wdata = i_memto_reg ? i_mem_data : i_alu_data;
    end

endmodule

// File: rtl/wb_regfile.sv
// Writeback stage register file: 32 x 32-bit, two combinational read ports,
// one write port. After reset the array is zeroed by a 32-cycle sweep before
// Ready is raised.
// Optional build macro: WB_BYPASS_EN enables same-cycle write-to-read bypass.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | sweeping reg[ClrIdx] <= 0, writes ignored, reads return 0
// RUN   | normal operation, Ready=1, terminal until reset
module wb_regfile
    import mips_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     MemDataIn,
    input  logic [DATA_W-1:0]     ALUDataIn,
    input  logic [REG_ADDR_W-1:0] WriteBackRegIn,
    input  logic                  RegWriteIn,
    input  logic                  MemtoRegIn,
    input  logic [REG_ADDR_W-1:0] ReadReg1,
    input  logic [REG_ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0]     ReadData1,
    output logic [DATA_W-1:0]     ReadData2,
    output logic [DATA_W-1:0]     WriteData,
    output logic                  Ready
);

    state_t                r_state;
    state_t                w_state_next;
    logic [REG_ADDR_W-1:0] r_clr_idx;
    logic [REG_ADDR_W-1:0] w_clr_idx_next;
    logic [DATA_W-1:0]     r_regs [NUM_REGS];
    logic                  w_wr_en;

    wb_select u_wb_select (
        .i_mem_data  (MemDataIn),
        .i_alu_data  (ALUDataIn),
        .i_memto_reg (MemtoRegIn),
        .o_wdata     (WriteData)
    );

    assign w_wr_en = (r_state == RUN) && RegWriteIn && (WriteBackRegIn != '0);

    // State and sweep index register; reset restarts the sweep from index 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= CLEAR;
            r_clr_idx <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_idx <= w_clr_idx_next;
        end
    end

    // Next state: sweep advances one register per edge, leaves CLEAR after reg 31.
    always_comb begin
        w_state_next   = r_state;
        w_clr_idx_next = r_clr_idx;
        if (r_state == CLEAR) begin
            w_clr_idx_next = r_clr_idx + 1'b1;
            if (r_clr_idx == REG_ADDR_W'(NUM_REGS - 1)) begin
                w_state_next = RUN;
            end
        end
    end

    // FSM output: Ready marks the RUN state only.
    always_comb begin
        Ready = (r_state == RUN);
    end

    // Array has no reset; it is zeroed by the sweep, written by the pipeline in RUN.
    always_ff @(posedge clk) begin
        if (r_state == CLEAR) begin
            r_regs[r_clr_idx] <= '0;
        end else if (w_wr_en) begin
            r_regs[WriteBackRegIn] <= WriteData;
        end
    end

    // Read ports: zero while clearing, reg 0 hard-wired to zero.
    always_comb begin
        ReadData1 = '0;
        ReadData2 = '0;
        if (r_state == RUN) begin
            ReadData1 = r_regs[ReadReg1];
            ReadData2 = r_regs[ReadReg2];
`ifdef WB_BYPASS_EN
            if (w_wr_en && (ReadReg1 == WriteBackRegIn)) ReadData1 = WriteData;
            if (w_wr_en && (ReadReg2 == WriteBackRegIn)) ReadData2 = WriteData;
`endif
            if (ReadReg1 == '0) ReadData1 = '0;
            if (ReadReg2 == '0) ReadData2 = '0;
        end
    end

endmodule

// File: doc/wb_regfile.md
WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 The block SHALL use one clock, clk, and an asynchronous, active-high reset, reset.
REQ-002 The block SHALL declare its ports in this order, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- MemDataIn  in  32  load data from the MEM/WB register
- ALUDataIn  in  32  ALU result from the MEM/WB register
- WriteBackRegIn  in  5  destination register
- RegWriteIn  in  1  write enable
- MemtoRegIn  in  1  1 = select MemDataIn, 0 = select ALUDataIn
- ReadReg1  in  5  read address, port 1
- ReadReg2  in  5  read address, port 2
- ReadData1  out  32  read data, port 1
- ReadData2  out  32  read data, port 2
- WriteData  out  32  selected writeback value, for forwarding
- Ready  out  1  register file initialised and accepting writes

Function
REQ-003 WriteData SHALL be combinational: MemtoRegIn ? MemDataIn : ALUDataIn.
REQ-004 The block SHALL hold 32 registers of 32 bits each.
REQ-005 Register 0 SHALL always read as 0; writes to register 0 SHALL be discarded.
REQ-006 In RUN, when RegWriteIn=1 and WriteBackRegIn!=0, reg[WriteBackRegIn] SHALL take WriteData on the rising edge of clk.
REQ-007 ReadData1 and ReadData2 SHALL be combinational (zero latency) from the register array.
REQ-008 The block SHALL implement a two-state FSM, CLEAR and RUN.
REQ-009 In CLEAR, each rising edge SHALL write 0 to reg[ClrIdx] and then increment the 5-bit ClrIdx.
REQ-010 In CLEAR, when ClrIdx=31, the FSM SHALL move to RUN on that same edge; Ready SHALL be 1 from the cycle after that edge.
REQ-011 Ready SHALL be 1 exactly in state RUN, which is reached on the 32nd rising edge after reset deasserts.
REQ-012 In CLEAR, RegWriteIn SHALL be ignored (no write) and ReadData1/ReadData2 SHALL return 0. The upstream pipeline is required to stall while Ready=0.
REQ-013 RUN SHALL be terminal until the next reset.
REQ-014 Both read ports addressing the same register SHALL return identical data.

Reset
REQ-015 Asserting reset SHALL immediately force: state=CLEAR, ClrIdx=0, Ready=0, ReadData1=0, ReadData2=0.
REQ-016 The register array SHALL NOT be reset asynchronously; it is zeroed only by the CLEAR sweep.
REQ-017 Reset asserted in either state, including mid-sweep, SHALL restart the sweep from index 0.

Configuration
REQ-018 With WB_BYPASS_EN defined: in RUN, if RegWriteIn=1, WriteBackRegIn!=0 and ReadRegX==WriteBackRegIn, then ReadDataX SHALL equal WriteData in the same cycle (write-before-read).
REQ-019 Without WB_BYPASS_EN: ReadDataX SHALL return the array contents (old value) until the edge after the write; the hazard unit resolves the gap.

Structure
REQ-020 Package mips_pkg SHALL hold: DATA_W=32, REG_ADDR_W=5, NUM_REGS=32, and the FSM state enum {CLEAR, RUN}.
REQ-021 The writeback select SHALL be a sub-module, wb_select (MemtoRegIn mux); the FSM and array SHALL stay in wb_regfile.

Verification
REQ-022 Reset released; count edges -> Ready=0 for edges 1..31 and 1 after edge 32; all 32 registers then read 0.
REQ-023 RUN, MemtoRegIn=0, ALUDataIn=0x0000_00AA, WriteBackRegIn=5, RegWriteIn=1, ReadReg1=5 -> WriteData=0xAA; ReadData1=0xAA same cycle with WB_BYPASS_EN, next cycle without.
REQ-024 MemtoRegIn=1, MemDataIn=0xDEAD_BEEF, WriteBackRegIn=0, RegWriteIn=1 -> ReadData1 with ReadReg1=0 stays 0 in every build.
REQ-025 reg[7]=0x1234, then reset pulsed at sweep index 10 -> Ready drops immediately, sweep restarts from 0, and reg[7] reads 0 once Ready=1.
REQ-026 During CLEAR drive RegWriteIn=1, WriteBackRegIn=3, ALUDataIn=0x55 -> reg[3] reads 0 after Ready=1.
